fetch_ctrl: RTL

- Sequences the program counter and the instruction-memory fetch handshake for the RISC-V core.
- Owns the PC register and issues one fetch request at a time to instruction memory.
- Buffers the returned instruction in a one-entry slot for decode.
- Applies branch/jump redirects from the next-PC logic, discarding any in-flight stale fetch.

---
 rtl/fetch_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencing and one-at-a-time instruction fetch with a one-entry decode slot.
// Ports: clk/rst (sync active-high reset); redirect_valid/redirect_pc restart fetch at a new target;
//    imem_req/imem_addr/imem_ack/imem_rdata form the instruction-memory handshake;
//    if_valid/if_pc/if_pc4/if_inst present the slot to decode, consumed when id_ready is high.
// Optional macro FETCH_STATS_EN adds stat_fetched/stat_dropped saturating counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc4,
   output logic [XLEN-1:0] if_inst,
   input  logic            id_ready
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]     stat_fetched,
   output logic [31:0]     stat_dropped
`endif
);
   typedef enum logic {S_REQ, S_HOLD} state_t;
   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, if_pc_q, if_pc_d, if_inst_q, if_inst_d, rpc;
   logic            pend_q, pend_d, if_valid_q, if_valid_d, drop;
   assign rpc       = redirect_pc & ~XLEN'(3);
   assign imem_req  = (state_q == S_REQ) && !rst;
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_pc4    = if_pc_q + XLEN'(4);
   assign if_inst   = if_inst_q;
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      drop       = 1'b0;
      if (state_q == S_REQ) begin
         if (imem_ack) begin
            // A redirect seen now or earlier makes this response stale; the newest target wins.
            if (redirect_valid || pend_q) begin
               pc_d   = redirect_valid ? rpc : pend_pc_q;
               pend_d = 1'b0;
               drop   = 1'b1;
            end else begin
               if_valid_d = 1'b1;
               if_pc_d    = pc_q;
               if_inst_d  = imem_rdata;
               pc_d       = pc_q + XLEN'(4);
               state_d    = S_HOLD;
            end
         end else if (redirect_valid) begin
            // The outstanding request cannot be withdrawn, so remember where to go once it returns.
            pend_d    = 1'b1;
            pend_pc_d = rpc;
         end
      end else if (redirect_valid || id_ready) begin
         if_valid_d = 1'b0;
         state_d    = S_REQ;
         pc_d       = redirect_valid ? rpc : pc_q;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d, stat_dropped_q, stat_dropped_d;
   logic        fetched;
   assign fetched      = if_valid_q && id_ready && !redirect_valid;
   assign stat_fetched = stat_fetched_q;
   assign stat_dropped = stat_dropped_q;
   always_comb begin
      stat_fetched_d = (fetched && stat_fetched_q != '1) ? stat_fetched_q + 32'd1 : stat_fetched_q;
      stat_dropped_d = (drop && stat_dropped_q != '1) ? stat_dropped_q + 32'd1 : stat_dropped_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_fetched_q <= '0;
         stat_dropped_q <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_dropped_q <= stat_dropped_d;
      end
   end
`else
   logic unused_drop;
   assign unused_drop = drop;
`endif
endmodule
